divisor_seq_nbits: RTL and testbench
====================================

Name: divisor_seq_nbits

Overview:
- Parametrised multi-cycle restoring divider.
- Produces quotient and remainder of W-bit operands, resolving one quotient bit per clock. It takes over from the 4-bit combinational divider where width grows and area/timing matter.
- Uses a start/done handshake and flags divide-by-zero.
- Sits between the operand registers and the result/display path of the ALU datapath.

Parameters:
- W, 4, operand/result width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in a cycle where ready=1.
- a  input  W  dividend, sampled in the accept cycle.
- b  input  W  divisor, sampled in the accept cycle.
- ready  output  1  high in IDLE and DONE; new start accepted.
- done  output  1  one-cycle pulse when q/r/err become valid.
- q  output  W  quotient, held until the next accepted start.
- r  output  W  remainder, held until the next accepted start.
- err  output  1  1 = last operation had b==0; held with q/r.

Behaviour:
- Clock is clk; reset is synchronous, active-high (rst).
- Reset state: IDLE. ready=1, done=0, q=0, r=0, err=0, iteration counter=0.
- rst high mid-operation aborts the operation. Outputs return to reset values on that edge, and no done pulse is issued.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE + start: capture a, b. Clear the partial remainder (W+1 bits) and the counter.
    - b==0 -> DONE directly.
    - otherwise -> BUSY.
  - IDLE/DONE without start: DONE -> IDLE after one cycle. q/r/err stay held.
  - BUSY: each cycle, shift the partial remainder left and bring in the next dividend bit, MSB first. Trial-subtract b at W+1 bits.
    - No borrow: keep the difference and shift in quotient bit 1.
    - Borrow: restore (keep the shifted value) and shift in quotient bit 0.
    - After W iterations, register q/r, set err=0, and go to DONE.
  - done=1 only in the first cycle of DONE.
- Latency, start accepted in cycle 0:
  - normal: done in cycle W+1.
  - b==0: done in cycle 1.
- Divide-by-zero result: q = all ones, r = a, err=1.
- start while BUSY is ignored: no capture, no effect on the running operation.
- start in the DONE cycle (ready=1) is accepted. The done pulse still occurs, and the FSM goes straight to BUSY (or DONE again if b==0).
- q/r/err change only on the edge that produces done, or on reset.
- Unsigned arithmetic (base build): a = q*b + r, with r < b.

Optional Feature:
- Macro: DIVISOR_SIGNED_EN.
- Defined: operands are two's complement.
  - Absolute values are captured at accept. The unsigned core runs unchanged.
  - One extra FIXUP state after BUSY negates q if the operand signs differ, and gives r the sign of a (truncating division).
  - Latency becomes W+2. b==0 handling is unchanged (q = all ones, r = a, err=1).
  - Most-negative / -1 wraps to the most-negative value with r=0 and err=0.
- Undefined: purely unsigned; no FIXUP state.

Test Plan:
- W=4, a=13, b=3, start in cycle 0 -> done in cycle 5 only; q=4, r=1, err=0; ready low in cycles 1-4.
- W=4, a=9, b=0 -> done in cycle 1; q=4'b1111, r=9, err=1. A following a=8, b=2 -> q=4, r=0, err=0.
- W=4, a=15, b=1 then a=2, b=7 -> q=15, r=0; then q=0, r=2.
- W=4, start pulsed again in cycle 2 with a=1, b=1 while BUSY from a=12, b=5 -> ignored; result q=2, r=2.
- W=8, a=200, b=7, with rst asserted in cycle 4 -> no done; cycle 5 shows q=0, r=0, err=0, ready=1. A new start then gives q=28, r=4 in cycle 9 after its accept.
- DIVISOR_SIGNED_EN, W=4, a=-7 (4'b1001), b=2 -> done in cycle 6; q=-3 (4'b1101), r=-1 (4'b1111).

Source files
------------

// File: rtl/divisor_seq_nbits.sv
// divisor_seq_nbits
// -----------------------------------------------------------------------------
// Multi-cycle restoring divider for the ALU datapath. It resolves one quotient
// bit per clock, so it takes over from the 4-bit combinational divider once
// operand widths grow.
//
// Parameters:
//   W      operand/result width in bits (W >= 2)
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset; aborts any running operation
//   start  request, accepted only while ready=1
//   a, b   dividend / divisor, sampled in the accept cycle
//   ready  high in IDLE and DONE
//   done   one-cycle pulse when q/r/err become valid
//   q, r   quotient / remainder, held until the next accepted start
//   err    1 = last operation divided by zero (q=all ones, r=a)
//
// Build option:
//   DIVISOR_SIGNED_EN  two's-complement operands. Magnitudes are divided by the
//                      unsigned core, and a FIXUP state then applies the signs
//                      (truncating division). Latency grows by one cycle.
// -----------------------------------------------------------------------------
module divisor_seq_nbits #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         err
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef DIVISOR_SIGNED_EN
    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t         r_state;
    state_t         w_nextState;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_dvd;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_err;
    logic           w_ready;
    logic           w_done;
    logic           w_accept;
    logic           w_lastIter;
    logic [W-1:0]   w_aMag;
    logic [W-1:0]   w_bMag;
    logic [W:0]     w_shift;
    logic [W:0]     w_diff;
    logic           w_borrow;
    logic [W-1:0]   w_remNext;
    logic [W-1:0]   w_quoNext;

`ifdef DIVISOR_SIGNED_EN
    logic r_signA;
    logic r_signB;

    assign w_aMag = a[W-1] ? -a : a;
    assign w_bMag = b[W-1] ? -b : b;
`else
    assign w_aMag = a;
    assign w_bMag = b;
`endif

    // The partial remainder is always below the divisor, so storing W bits
    // suffices; the shifted value needs W+1 bits. Because shifted < 2*divisor,
    // bit W of the W+1-bit difference is exactly the borrow of the trial
    // subtract. r_dvd shifts dividend bits out of its MSB while quotient bits
    // enter at its LSB, so after W steps it holds the quotient.
    assign w_shift   = {r_rem, r_dvd[W-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_borrow  = w_diff[W];
    assign w_remNext = w_borrow ? w_shift[W-1:0] : w_diff[W-1:0];
    assign w_quoNext = {r_dvd[W-2:0], ~w_borrow};

    assign w_lastIter = (r_state == BUSY) && (r_cnt == LAST);

    // State register; reset drops any running operation back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode. DONE behaves like IDLE for accepting a
    // new start, so a back-to-back request loses no cycle. A zero divisor
    // skips BUSY entirely.
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_ready  = 1'b1;
                w_done   = (r_state == DONE);
                w_accept = start;
                if (start) begin
                    w_nextState = (b == '0) ? DONE : BUSY;
                end else begin
                    w_nextState = IDLE;
                end
            end
            BUSY: begin
                if (w_lastIter) begin
`ifdef DIVISOR_SIGNED_EN
                    w_nextState = FIXUP;
`else
                    w_nextState = DONE;
`endif
                end
            end
`ifdef DIVISOR_SIGNED_EN
            FIXUP: begin
                w_nextState = DONE;
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. The visible results (r_q/r_r/r_err) are written only on the
    // edge that enters DONE, so they stay stable for the whole next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_err <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
            r_signA <= 1'b0;
            r_signB <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= w_aMag;
            r_div <= w_bMag;
`ifdef DIVISOR_SIGNED_EN
            r_signA <= a[W-1];
            r_signB <= b[W-1];
`endif
            if (b == '0) begin
                r_q   <= '1;
                r_r   <= a;
                r_err <= 1'b1;
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_remNext;
            r_dvd <= w_quoNext;
            r_cnt <= r_cnt + 1'b1;
`ifndef DIVISOR_SIGNED_EN
            if (w_lastIter) begin
                r_q   <= w_quoNext;
                r_r   <= w_remNext;
                r_err <= 1'b0;
            end
`endif
        end
`ifdef DIVISOR_SIGNED_EN
        // Truncating division: the quotient is negative when the signs differ,
        // and the remainder follows the dividend's sign.
        else if (r_state == FIXUP) begin
            r_q   <= (r_signA ^ r_signB) ? -r_dvd : r_dvd;
            r_r   <= r_signA ? -r_rem : r_rem;
            r_err <= 1'b0;
        end
`endif
    end

    assign ready = w_ready;
    assign done  = w_done;
    assign q     = r_q;
    assign r     = r_r;
    assign err   = r_err;

endmodule

// File: tb/tb_divisor_seq_nbits.sv
// tb_divisor_seq_nbits
// -----------------------------------------------------------------------------
// Directed bench for divisor_seq_nbits. One W=4 and one W=8 instance share a
// clock. Cycle n is the interval after rising edge n; inputs are driven and
// outputs sampled 1 time unit after the edge. Expected values are hand
// computed. Signed vectors are used when DIVISOR_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_divisor_seq_nbits;

`ifdef DIVISOR_SIGNED_EN
    localparam int LAT4 = 6;
    localparam int LAT8 = 10;
`else
    localparam int LAT4 = 5;
    localparam int LAT8 = 9;
`endif

    logic       clk;
    logic       rst4;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ready4;
    logic       done4;
    logic [3:0] q4;
    logic [3:0] r4;
    logic       err4;

    logic       rst8;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       ready8;
    logic       done8;
    logic [7:0] q8;
    logic [7:0] r8;
    logic       err8;

    int nTests;
    int nFail;

    logic [3:0] lastQ4;
    logic [3:0] lastR4;
    logic       lastE4;

    divisor_seq_nbits #(.W(4)) dut4 (
        .clk   (clk),
        .rst   (rst4),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .ready (ready4),
        .done  (done4),
        .q     (q4),
        .r     (r4),
        .err   (err4)
    );

    divisor_seq_nbits #(.W(8)) dut8 (
        .clk   (clk),
        .rst   (rst8),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ready (ready8),
        .done  (done8),
        .q     (q8),
        .r     (r8),
        .err   (err8)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nTests++;
        if (observed !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present a request to the W=4 instance in the current cycle.
    task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb);
        start4 = 1'b1;
        a4     = ta;
        b4     = tb;
    endtask

    // Walk the W=4 instance through lat cycles after an accept: done/ready
    // must stay low until the last cycle, previous results must be held, and
    // the final cycle must show the new result.
    task automatic waitResult(input string tag, input int lat, input logic [3:0] eq,
                              input logic [3:0] er, input logic ee);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c == 1) start4 = 1'b0;
            checkOutput({tag, "_done"}, done4, (c == lat) ? 1 : 0);
            checkOutput({tag, "_ready"}, ready4, (c == lat) ? 1 : 0);
            if (c < lat) checkOutput({tag, "_hold_q"}, q4, lastQ4);
            if (c < lat) checkOutput({tag, "_hold_r"}, r4, lastR4);
            if (c < lat) checkOutput({tag, "_hold_err"}, err4, lastE4);
        end
        checkOutput({tag, "_q"}, q4, eq);
        checkOutput({tag, "_r"}, r4, er);
        checkOutput({tag, "_err"}, err4, ee);
        lastQ4 = eq;
        lastR4 = er;
        lastE4 = ee;
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        lastQ4 = '0;
        lastR4 = '0;
        lastE4 = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", ready4, 1);
        checkOutput("rst_done", done4, 0);
        checkOutput("rst_q", q4, 0);
        checkOutput("rst_r", r4, 0);
        checkOutput("rst_err", err4, 0);
        checkOutput("rst8_ready", ready8, 1);
        rst4 = 1'b0;
        rst8 = 1'b0;

        // ---------------- W=4 ----------------
`ifdef DIVISOR_SIGNED_EN
        @(posedge clk); #1;
        applyStimulus(4'b1001, 4'd2);           // -7 / 2 = -3 r -1
        waitResult("s_m7d2", LAT4, 4'b1101, 4'b1111, 1'b0);
        @(posedge clk); #1;
        applyStimulus(4'b1000, 4'b1111);        // -8 / -1 wraps to -8 r 0
        waitResult("s_wrap", LAT4, 4'b1000, 4'd0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(4'd7, 4'b1110);           // 7 / -2 = -3 r 1
        waitResult("s_7dm2", LAT4, 4'b1101, 4'd1, 1'b0);
        @(posedge clk); #1;
        applyStimulus(4'b1001, 4'd0);           // -7 / 0
        waitResult("s_div0", 1, 4'b1111, 4'b1001, 1'b1);
`else
        @(posedge clk); #1;
        applyStimulus(4'd13, 4'd3);
        waitResult("u13d3", LAT4, 4'd4, 4'd1, 1'b0);

        @(posedge clk); #1;
        applyStimulus(4'd9, 4'd0);
        waitResult("u9d0", 1, 4'b1111, 4'd9, 1'b1);
        @(posedge clk); #1;
        applyStimulus(4'd8, 4'd2);
        waitResult("u8d2", LAT4, 4'd4, 4'd0, 1'b0);

        // Second request issued in the DONE cycle of the first.
        @(posedge clk); #1;
        applyStimulus(4'd15, 4'd1);
        waitResult("u15d1", LAT4, 4'd15, 4'd0, 1'b0);
        applyStimulus(4'd2, 4'd7);
        waitResult("u2d7", LAT4, 4'd0, 4'd2, 1'b0);

        // start pulsed in cycle 2 while BUSY must be ignored.
        @(posedge clk); #1;
        applyStimulus(4'd12, 4'd5);
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        checkOutput("ign_ready", ready4, 0);
        applyStimulus(4'd1, 4'd1);
        waitResult("u12d5", LAT4 - 2, 4'd2, 4'd2, 1'b0);
        @(posedge clk); #1;
        checkOutput("ign_after_done", done4, 0);
        checkOutput("ign_after_q", q4, 2);
`endif

        // ---------------- W=8, abort by reset ----------------
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd9;
        for (int c = 1; c <= LAT8; c++) begin
            @(posedge clk); #1;
            if (c == 1) start8 = 1'b0;
            checkOutput("w8a_done", done8, (c == LAT8) ? 1 : 0);
        end
        checkOutput("w8a_q", q8, 11);
        checkOutput("w8a_r", r8, 1);
        checkOutput("w8a_err", err8, 0);

        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd7;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) start8 = 1'b0;
            checkOutput("w8abort_busy_done", done8, 0);
            if (c == 4) rst8 = 1'b1;
        end
        @(posedge clk); #1;
        rst8 = 1'b0;
        checkOutput("w8abort_q", q8, 0);
        checkOutput("w8abort_r", r8, 0);
        checkOutput("w8abort_err", err8, 0);
        checkOutput("w8abort_ready", ready8, 1);
        checkOutput("w8abort_done", done8, 0);
        for (int c = 0; c < LAT8; c++) begin
            @(posedge clk); #1;
            checkOutput("w8abort_nodone", done8, 0);
        end

        start8 = 1'b1; a8 = 8'd200; b8 = 8'd7;
        for (int c = 1; c <= LAT8; c++) begin
            @(posedge clk); #1;
            if (c == 1) start8 = 1'b0;
            checkOutput("w8b_done", done8, (c == LAT8) ? 1 : 0);
        end
`ifdef DIVISOR_SIGNED_EN
        checkOutput("w8b_q", q8, 8'hF8);        // -56 / 7 = -8
        checkOutput("w8b_r", r8, 0);
`else
        checkOutput("w8b_q", q8, 28);
        checkOutput("w8b_r", r8, 4);
`endif
        checkOutput("w8b_err", err8, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
